// File: rtl/date_set_ctrl.sv
// Watch calendar controller: holds year/month/day/weekday, advances on midnight ticks and
// sequences the year -> month -> day edit flow with a one-cycle weekday recompute on commit.
module date_set_ctrl #(
   parameter int unsigned YEAR_MIN     = 2000,
   parameter int unsigned YEAR_MAX     = 2099,
   parameter int unsigned IDLE_TIMEOUT = 3000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tick_day_i,
   input  logic        btn_mode_i,
   input  logic        btn_inc_i,
   input  logic        btn_dec_i,
   output logic [14:0] year_o,
   output logic [6:0]  month_o,
   output logic [6:0]  day_o,
   output logic [2:0]  day_of_week_o,
   output logic [1:0]  mode_o,
   output logic        busy_o
);

   localparam logic [14:0] YMin = 15'(YEAR_MIN);
   localparam logic [14:0] YMax = 15'(YEAR_MAX);
   // Counter only needs to reach IDLE_TIMEOUT-1 before the commit fires.
   localparam int unsigned     CntW   = $clog2(IDLE_TIMEOUT);
   localparam logic [CntW-1:0] CntMax = CntW'(IDLE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StRun,
      StSetYear,
      StSetMonth,
      StSetDay,
      StCalc
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [14:0]     year_q, year_d;
   logic [6:0]      month_q, month_d;
   logic [6:0]      day_q, day_d;
   logic [2:0]      dow_q, dow_d;
   logic            pending_q, pending_d;

   logic        any_btn, step, timed_out, advance, at_end;
   logic [14:0] adv_year;
   logic [6:0]  adv_month, adv_day;
   logic [2:0]  adv_dow;

   function automatic logic is_leap(input logic [14:0] y);
      return ((y % 15'd4) == 15'd0) &&
             (((y % 15'd100) != 15'd0) || ((y % 15'd400) == 15'd0));
   endfunction

   function automatic logic [6:0] dim(input logic [6:0] m, input logic [14:0] y);
      logic [6:0] r;
      case (m)
         7'd2:                    r = is_leap(y) ? 7'd29 : 7'd28;
         7'd4, 7'd6, 7'd9, 7'd11: r = 7'd30;
         default:                 r = 7'd31;
      endcase
      return r;
   endfunction

   // Sakamoto's weekday formula, 0 = Sunday.
   function automatic logic [2:0] sakamoto(input logic [14:0] y, input logic [6:0] m,
                                           input logic [6:0] d);
      logic [15:0] yy;
      logic [15:0] s;
      logic [2:0]  t;
      yy = {1'b0, y} - ((m < 7'd3) ? 16'd1 : 16'd0);
      case (m)
         7'd1:    t = 3'd0;
         7'd2:    t = 3'd3;
         7'd3:    t = 3'd2;
         7'd4:    t = 3'd5;
         7'd5:    t = 3'd0;
         7'd6:    t = 3'd3;
         7'd7:    t = 3'd5;
         7'd8:    t = 3'd1;
         7'd9:    t = 3'd4;
         7'd10:   t = 3'd6;
         7'd11:   t = 3'd2;
         7'd12:   t = 3'd4;
         default: t = 3'd0;
      endcase
      s = yy + yy / 16'd4 - yy / 16'd100 + yy / 16'd400 + {13'd0, t} + {9'd0, d};
      return 3'(s % 16'd7);
   endfunction

   assign any_btn   = btn_mode_i | btn_inc_i | btn_dec_i;
   assign step      = !btn_mode_i && (btn_inc_i ^ btn_dec_i);
   assign timed_out = !any_btn && (cnt_q == CntMax);
   assign advance   = tick_day_i | pending_q;
   assign at_end    = (year_q == YMax) && (month_q == 7'd12) && (day_q == 7'd31);

   always_comb begin : p_advance
      adv_day   = day_q + 7'd1;
      adv_month = month_q;
      adv_year  = year_q;
      if (day_q >= dim(month_q, year_q)) begin
         adv_day = 7'd1;
         if (month_q == 7'd12) begin
            adv_month = 7'd1;
            adv_year  = at_end ? YMin : year_q + 15'd1;
         end else begin
            adv_month = month_q + 7'd1;
         end
      end
      adv_dow = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
   end

   always_ff @(posedge clk_i) begin : p_state
      if (rst_i) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin : p_next
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StRun: begin
            if (advance && at_end) begin
               state_d = StCalc;
            end else if (btn_mode_i) begin
               state_d = StSetYear;
            end
         end
         StSetYear, StSetMonth, StSetDay: begin
            if (btn_mode_i) begin
               unique case (state_q)
                  StSetYear:  state_d = StSetMonth;
                  StSetMonth: state_d = StSetDay;
                  default:    state_d = StCalc;
               endcase
            end else if (timed_out) begin
               state_d = StCalc;
            end
            cnt_d = (any_btn || timed_out) ? '0 : cnt_q + 1'b1;
         end
         StCalc:  state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_comb begin : p_outputs
      busy_o = (state_q == StCalc);
      unique case (state_q)
         StSetYear:  mode_o = 2'd1;
         StSetMonth: mode_o = 2'd2;
         StSetDay:   mode_o = 2'd3;
         default:    mode_o = 2'd0;
      endcase
   end

   always_comb begin : p_data
      logic [14:0] ny;
      logic [6:0]  nm;
      logic [6:0]  lim;
      year_d    = year_q;
      month_d   = month_q;
      day_d     = day_q;
      dow_d     = dow_q;
      pending_d = pending_q;
      ny        = year_q;
      nm        = month_q;
      lim       = dim(month_q, year_q);
      unique case (state_q)
         StRun: begin
            // A tick arriving alongside a pending advance is absorbed into it.
            pending_d = 1'b0;
            if (advance) begin
               year_d  = adv_year;
               month_d = adv_month;
               day_d   = adv_day;
               dow_d   = adv_dow;
            end
         end
         StSetYear: begin
            pending_d = pending_q | tick_day_i;
            if (step) begin
               if (btn_inc_i) ny = (year_q >= YMax) ? YMin : year_q + 15'd1;
               else           ny = (year_q <= YMin) ? YMax : year_q - 15'd1;
               lim    = dim(month_q, ny);
               year_d = ny;
               day_d  = (day_q > lim) ? lim : day_q;
            end
         end
         StSetMonth: begin
            pending_d = pending_q | tick_day_i;
            if (step) begin
               if (btn_inc_i) nm = (month_q >= 7'd12) ? 7'd1 : month_q + 7'd1;
               else           nm = (month_q <= 7'd1) ? 7'd12 : month_q - 7'd1;
               lim     = dim(nm, year_q);
               month_d = nm;
               day_d   = (day_q > lim) ? lim : day_q;
            end
         end
         StSetDay: begin
            pending_d = pending_q | tick_day_i;
            if (step) begin
               if (btn_inc_i) day_d = (day_q >= lim) ? 7'd1 : day_q + 7'd1;
               else           day_d = (day_q <= 7'd1) ? lim : day_q - 7'd1;
            end
         end
         StCalc: begin
            pending_d = pending_q | tick_day_i;
            dow_d     = sakamoto(year_q, month_q, day_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin : p_regs
      if (rst_i) begin
         year_q    <= YMin;
         month_q   <= 7'd1;
         day_q     <= 7'd1;
         dow_q     <= 3'd6;
         pending_q <= 1'b0;
      end else begin
         year_q    <= year_d;
         month_q   <= month_d;
         day_q     <= day_d;
         dow_q     <= dow_d;
         pending_q <= pending_d;
      end
   end

   assign year_o        = year_q;
   assign month_o       = month_q;
   assign day_o         = day_q;
   assign day_of_week_o = dow_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed bench for date_set_ctrl: a vector table for the edit flow plus hand sequences
// for reset, month/leap rollover, pending ticks, idle timeout and the end-of-range wrap.
module tb_date_set_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_day, btn_mode, btn_inc, btn_dec;
   logic [14:0] year;
   logic [6:0]  month, day;
   logic [2:0]  dow;
   logic [1:0]  mode;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        t, m, i, d;
      logic [14:0] y;
      logic [6:0]  mo, dd;
      logic [2:0]  w;
      logic [1:0]  md;
      logic        b;
   } vec_t;

   vec_t tbl[$];

   date_set_ctrl #(
      .YEAR_MIN    (2000),
      .YEAR_MAX    (2099),
      .IDLE_TIMEOUT(16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .tick_day_i   (tick_day),
      .btn_mode_i   (btn_mode),
      .btn_inc_i    (btn_inc),
      .btn_dec_i    (btn_dec),
      .year_o       (year),
      .month_o      (month),
      .day_o        (day),
      .day_of_week_o(dow),
      .mode_o       (mode),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int t, input int m, input int i, input int d,
                               input int y, input int mo, input int dd, input int w,
                               input int md, input int b);
      vec_t v;
      v.t  = 1'(t);
      v.m  = 1'(m);
      v.i  = 1'(i);
      v.d  = 1'(d);
      v.y  = 15'(y);
      v.mo = 7'(mo);
      v.dd = 7'(dd);
      v.w  = 3'(w);
      v.md = 2'(md);
      v.b  = 1'(b);
      return v;
   endfunction

   // One clock with the given pulses; returns 1 time unit after the edge.
   task automatic cyc(input logic t, input logic m, input logic i, input logic d);
      tick_day = t;
      btn_mode = m;
      btn_inc  = i;
      btn_dec  = d;
      @(posedge clk);
      #1;
      tick_day = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk(input string name, input int y, input int mo, input int dd,
                      input int w, input int md, input int b);
      logic [34:0] act, exp;
      act = {year, month, day, dow, mode, busy};
      exp = {15'(y), 7'(mo), 7'(dd), 3'(w), 2'(md), 1'(b)};
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d-%0d-%0d dow=%0d mode=%0d busy=%0d, want %0d-%0d-%0d dow=%0d mode=%0d busy=%0d",
                  name, year, month, day, dow, mode, busy, y, mo, dd, w, md, b);
      end
   endtask

   initial begin
      rst      = 1'b1;
      tick_day = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;

      // Starting from 2000-01-31 (Mon) in RUN.
      tbl.push_back(mk(0, 1, 0, 0, 2000, 1, 31, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 2001, 1, 31, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2001, 1, 31, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2001, 1, 31, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 0, 2001, 2, 28, 1, 2, 0));
      tbl.push_back(mk(0, 0, 0, 0, 2001, 2, 28, 1, 2, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2001, 2, 28, 1, 3, 0));
      tbl.push_back(mk(0, 0, 1, 0, 2001, 2, 1, 1, 3, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2001, 2, 28, 1, 3, 0));
      tbl.push_back(mk(0, 1, 1, 0, 2001, 2, 28, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 2001, 2, 28, 3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 2001, 2, 28, 3, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 2001, 3, 1, 4, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2001, 3, 2, 5, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2000, 3, 2, 5, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 3, 2, 5, 2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2000, 2, 2, 5, 2, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 2, 2, 5, 3, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2000, 2, 1, 5, 3, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2000, 2, 29, 5, 3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 2, 29, 5, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 2000, 2, 29, 2, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 2, 29, 2, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 2001, 2, 28, 2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 2000, 2, 28, 2, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 2, 28, 2, 2, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 2, 28, 2, 3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2000, 2, 28, 2, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 2000, 2, 28, 1, 0, 0));

      // Reset values, and reset mid-edit with a pending tick.
      do_reset(2);
      chk("reset", 2000, 1, 1, 6, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("enter_set_month", 2000, 1, 1, 6, 2, 0);
      cyc(1, 0, 0, 0);
      do_reset(1);
      chk("reset_mid_edit", 2000, 1, 1, 6, 0, 0);
      cyc(0, 0, 0, 0);
      chk("pending_dropped", 2000, 1, 1, 6, 0, 0);

      // Leap-day rollover.
      do_reset(1);
      repeat (59) cyc(1, 0, 0, 0);
      chk("tick59_feb29", 2000, 2, 29, 2, 0, 0);
      cyc(1, 0, 0, 0);
      chk("tick60_mar1", 2000, 3, 1, 3, 0, 0);

      // Vector table from 2000-01-31.
      do_reset(1);
      repeat (30) cyc(1, 0, 0, 0);
      chk("tick30_jan31", 2000, 1, 31, 1, 0, 0);
      for (int k = 0; k < tbl.size(); k++) begin
         cyc(tbl[k].t, tbl[k].m, tbl[k].i, tbl[k].d);
         chk($sformatf("tbl[%0d]", k), int'(tbl[k].y), int'(tbl[k].mo), int'(tbl[k].dd),
             int'(tbl[k].w), int'(tbl[k].md), int'(tbl[k].b));
      end

      // Two ticks while editing collapse into one advance after commit.
      do_reset(1);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("pend_calc", 2000, 1, 1, 6, 0, 1);
      cyc(0, 0, 0, 0);
      chk("pend_run0", 2000, 1, 1, 6, 0, 0);
      cyc(0, 0, 0, 0);
      chk("pend_advance", 2000, 1, 2, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("pend_once", 2000, 1, 2, 0, 0, 0);

      // Idle timeout, and inc+dec restarting it.
      do_reset(1);
      cyc(0, 1, 0, 0);
      repeat (15) cyc(0, 0, 0, 0);
      chk("idle15_still_set", 2000, 1, 1, 6, 1, 0);
      cyc(0, 0, 0, 0);
      chk("idle16_calc", 2000, 1, 1, 6, 0, 1);
      cyc(0, 0, 0, 0);
      chk("idle_back_run", 2000, 1, 1, 6, 0, 0);
      cyc(0, 1, 0, 0);
      repeat (10) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 1);
      repeat (15) cyc(0, 0, 0, 0);
      chk("incdec_restart", 2000, 1, 1, 6, 1, 0);
      cyc(0, 0, 0, 0);
      chk("incdec_timeout", 2000, 1, 1, 6, 0, 1);
      cyc(0, 0, 0, 0);

      // Field wrap down to 2099-12-31, commit, then the end-of-range wrap.
      do_reset(1);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      chk("year_wrap_dec", 2099, 1, 1, 6, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      chk("month_wrap_dec", 2099, 12, 1, 6, 2, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      chk("day_wrap_dec", 2099, 12, 31, 6, 3, 0);
      cyc(0, 1, 0, 0);
      chk("commit_calc", 2099, 12, 31, 6, 0, 1);
      cyc(0, 0, 0, 0);
      chk("dow_2099_12_31", 2099, 12, 31, 4, 0, 0);
      cyc(1, 0, 0, 0);
      chk("range_wrap_calc", 2000, 1, 1, 5, 0, 1);
      cyc(0, 0, 0, 0);
      chk("range_wrap_dow", 2000, 1, 1, 6, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
